// File: rtl/bram_stream_reader.sv
// Streams a burst of words out of a registered-read BRAM port onto a valid/ready stream.
// Optional macro BRAM_READER_STRIDE_EN adds a per-burst address stride input.
module bram_stream_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
`ifdef BRAM_READER_STRIDE_EN
   input  logic [ADDR_WIDTH-1:0] stride,
`endif
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic                  bram_we,
   input  logic [DATA_WIDTH-1:0] bram_dout,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);

   state_t                  state;
   logic [ADDR_WIDTH:0]     rem;
   logic [ADDR_WIDTH-1:0]   next_addr;
   logic [ADDR_WIDTH-1:0]   step;
   logic [ADDR_WIDTH-1:0]   step_in;
   logic                    vld_p0, last_p0;
   logic                    vld_p1, last_p1;
   logic [DATA_WIDTH-1:0]   fifo_data [2];
   logic                    fifo_last [2];
   logic                    wr_ptr, rd_ptr;
   logic [1:0]              fifo_cnt;
   logic [2:0]              used;
   logic [2:0]              limit;
   logic                    pop, issue, out_free;
   logic                    load_from_fifo, load_from_bram, push_fifo;

`ifdef BRAM_READER_STRIDE_EN
   assign step_in = stride;
`else
   assign step_in = ADDR_WIDTH'(1);
`endif

   assign bram_we = 1'b0;

   // Credits cover the output register plus the two FIFO slots; a word leaving
   // the output register frees one slot for a read issued in the same cycle.
   always_comb begin
      pop            = out_valid & out_ready;
      used           = {1'b0, fifo_cnt} + {2'b00, vld_p0} + {2'b00, vld_p1};
      limit          = pop ? 3'd3 : 3'd2;
      issue          = (state == RUN) && (used < limit);
      out_free       = !out_valid || pop;
      load_from_fifo = out_free && (fifo_cnt != 2'd0);
      load_from_bram = out_free && (fifo_cnt == 2'd0) && vld_p1;
      push_fifo      = vld_p1 && !load_from_bram;
   end

   // FIFO storage carries no reset; fifo_cnt alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push_fifo) begin
         fifo_data[wr_ptr] <= bram_dout;
         fifo_last[wr_ptr] <= last_p1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rem       <= '0;
         next_addr <= '0;
         step      <= '0;
         bram_addr <= '0;
         vld_p0    <= 1'b0;
         last_p0   <= 1'b0;
         vld_p1    <= 1'b0;
         last_p1   <= 1'b0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         fifo_cnt  <= 2'd0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         done <= 1'b0;

         // p0: address on the BRAM port; p1: its data on bram_dout
         vld_p0  <= issue;
         last_p0 <= issue && (rem == LEN_ONE);
         vld_p1  <= vld_p0;
         last_p1 <= last_p0;

         if (issue) begin
            bram_addr <= next_addr;
            next_addr <= next_addr + step;
            rem       <= rem - LEN_ONE;
         end

         if (push_fifo)      wr_ptr <= ~wr_ptr;
         if (load_from_fifo) rd_ptr <= ~rd_ptr;
         case ({push_fifo, load_from_fifo})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase

         if (load_from_fifo) begin
            out_data  <= fifo_data[rd_ptr];
            out_last  <= fifo_last[rd_ptr];
            out_valid <= 1'b1;
         end else if (load_from_bram) begin
            out_data  <= bram_dout;
            out_last  <= last_p1;
            out_valid <= 1'b1;
         end else if (pop) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  next_addr <= base_addr;
                  step      <= step_in;
                  rem       <= length;
                  busy      <= 1'b1;
                  if (length == '0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (issue && (rem == LEN_ONE)) state <= DRAIN;
            end
            DRAIN: begin
               if (pop && out_last) begin
                  state <= FIN;
                  done  <= 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: directed bursts plus randomized bursts
// compared against a queue model of the expected word stream.
module tb_bram_stream_reader;
   localparam int DW    = 32;
   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
`ifdef BRAM_READER_STRIDE_EN
   logic [AW-1:0] stride;
`endif
   logic          busy, done, bram_we, out_valid, out_ready, out_last;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_dout, out_data;
   logic [DW-1:0] mem [DEPTH];

   bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
`ifdef BRAM_READER_STRIDE_EN
      .stride(stride),
`endif
      .busy(busy), .done(done), .bram_addr(bram_addr), .bram_we(bram_we),
      .bram_dout(bram_dout), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last)
   );

   always #5 clk = ~clk;

   // Registered-read BRAM: data for an address appears the following cycle
   always @(posedge clk) bram_dout <= mem[bram_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready generator
   int         rmode = 0;
   int         ridx  = 0;
   logic [7:0] pat   = 8'b01101001;
   always @(posedge clk) begin
      #1;
      case (rmode)
         0:       out_ready = 1'b1;
         1:       begin out_ready = pat[ridx % 8]; ridx++; end
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Observation of the stream, handshakes and stall stability
   logic [DW-1:0] got_d [$];
   logic          got_l [$];
   int            fv_cyc = -1, acc_cyc_last = 0, done_cnt = 0, done_cyc = 0;
   int            busy_cnt = 0, stall_bad = 0, we_bad = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_d;
   logic          prev_l;
   always @(negedge clk) begin
      if (bram_we !== 1'b0) we_bad++;
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l))
         stall_bad++;
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_l     = out_last;
      if (out_valid === 1'b1) begin
         if (fv_cyc < 0) fv_cyc = cyc;
         if (out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
            acc_cyc_last = cyc;
         end
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (busy === 1'b1) busy_cnt++;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      got_d.delete();
      got_l.delete();
      fv_cyc    = -1;
      done_cnt  = 0;
      busy_cnt  = 0;
      stall_bad = 0;
   endtask

   // Called 1 time unit after a rising edge; returns at the same phase.
   task automatic run_burst(input int base, input int len, input int str, input int mode,
                            input bit inject, input string tag);
      logic [DW-1:0] exp_d [$];
      int st;
      int n;
      for (int k = 0; k < len; k++) exp_d.push_back(mem[(base + k * str) % DEPTH]);
      rmode = mode;
      ridx  = 0;
      clear_mon();
      base_addr = AW'(base);
      length    = (AW+1)'(len);
`ifdef BRAM_READER_STRIDE_EN
      stride    = AW'(str);
`endif
      start = 1'b1;
      st    = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      if (inject) begin
         @(posedge clk); #1;
         base_addr = AW'(base + 100);
         length    = (AW+1)'(5);
         start     = 1'b1;
         @(posedge clk); #1;
         start     = 1'b0;
      end
      n = 0;
      while (done_cnt == 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "_timeout"}, 64'(n >= 400), 64'(0));
      chk({tag, "_done_count"}, 64'(done_cnt), 64'(1));
      chk({tag, "_word_count"}, 64'(got_d.size()), 64'(len));
      for (int k = 0; k < len && k < got_d.size(); k++) begin
         chk($sformatf("%s_data%0d", tag, k), 64'(got_d[k]), 64'(exp_d[k]));
         chk($sformatf("%s_last%0d", tag, k), 64'(got_l[k]), 64'(k == len - 1));
      end
      if (len > 0) begin
         chk({tag, "_first_valid_lat"}, 64'(fv_cyc - st), 64'(4));
         chk({tag, "_done_after_last"}, 64'(done_cyc), 64'(acc_cyc_last + 1));
      end else begin
         chk({tag, "_no_valid"}, 64'(fv_cyc), 64'(-1));
         chk({tag, "_done_lat"}, 64'(done_cyc), 64'(st + 1));
      end
      chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(done_cyc - st));
      chk({tag, "_stall_stable"}, 64'(stall_bad), 64'(0));
      chk({tag, "_busy_idle"}, 64'(busy), 64'(0));
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
`ifdef BRAM_READER_STRIDE_EN
      stride    = '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 32'h100);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_last", 64'(out_last), 64'(0));
      chk("rst_addr", 64'(bram_addr), 64'(0));
      chk("rst_data", 64'(out_data), 64'(0));
      chk("rst_we", 64'(bram_we), 64'(0));
      rst = 1'b0;

      run_burst(4, 8, 1, 0, 1'b0, "basic");
      run_burst(0, 0, 1, 0, 1'b0, "len0");
      run_burst(1022, 4, 1, 0, 1'b0, "wrap");
      run_burst(10, 6, 1, 1, 1'b1, "stall");

      // Reset in the middle of a burst
      rmode = 0;
      clear_mon();
      base_addr = AW'(20);
      length    = (AW+1)'(8);
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (got_d.size() < 3 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("midrst_reached3", 64'(got_d.size() >= 3), 64'(1));
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_valid", 64'(out_valid), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_last", 64'(out_last), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      run_burst(0, 2, 1, 0, 1'b0, "after_rst");

`ifdef BRAM_READER_STRIDE_EN
      run_burst(0, 4, 3, 0, 1'b1, "stride3");
      run_burst(7, 3, 0, 2, 1'b0, "stride0");
`endif

      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      for (int r = 0; r < 10; r++) begin
`ifdef BRAM_READER_STRIDE_EN
         run_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, 12),
                   $urandom_range(0, DEPTH - 1), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                   $sformatf("rand%0d", r));
`else
         run_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, 12), 1,
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
`endif
      end

      chk("bram_we_low", 64'(we_bad), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the word width of BRAM read data and stream data.
REQ-002 Parameter ADDR_WIDTH, default 10, SHALL set the BRAM address width; memory depth is 2^ADDR_WIDTH.
REQ-003 Port list SHALL be as follows, clock and reset first:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a burst read.
- base_addr  in  ADDR_WIDTH  first word address, sampled with start.
- length  in  ADDR_WIDTH+1  word count, sampled with start; 0 is legal.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last word is accepted downstream.
- bram_addr  out  ADDR_WIDTH  read address to one BRAM port.
- bram_we  out  1  BRAM write enable; constant 0.
- bram_dout  in  DATA_WIDTH  registered BRAM read data, valid one cycle after its address.
- out_data  out  DATA_WIDTH  stream data.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  marks the final word of the burst; qualified by out_valid.

Function
REQ-004 The FSM SHALL have states IDLE, RUN, DRAIN and FIN.
- IDLE->RUN on start with length>0.
- IDLE->FIN on start with length==0.
- RUN->DRAIN after the last address issues.
- DRAIN->FIN when the last word is accepted.
- FIN->IDLE unconditionally.
REQ-005 start SHALL be accepted only in IDLE; start in any other state SHALL be ignored, with no effect on the burst in progress.
REQ-006 The word issued in the cycle a read is issued SHALL appear on bram_dout in the next cycle, and the block SHALL capture it in that cycle.
REQ-007 Internal buffering SHALL be a 2-entry FIFO.
- A read SHALL issue only when (FIFO occupancy + reads in flight - pop this cycle) < 2.
- Buffered data SHALL never be overwritten or dropped.
REQ-008 With out_ready held high, the block SHALL sustain one word per cycle.
- First out_valid SHALL be 3 cycles after the start-accept edge.
REQ-009 Word k (0-based) SHALL be read from address (base_addr + k*S) mod 2^ADDR_WIDTH.
- S = 1, or stride per REQ-016.
- The address SHALL wrap silently at 2^ADDR_WIDTH.
REQ-010 out_data, out_valid and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-011 out_last SHALL be 1 exactly on word length-1.
REQ-012 done SHALL pulse for one cycle in FIN.
- busy SHALL be 1 in RUN, DRAIN and FIN, and 0 in IDLE.
REQ-013 For length==0 there SHALL be no BRAM read and no out_valid; done SHALL pulse 1 cycle after start.
REQ-014 bram_addr SHALL hold its last value when no read issues.

Reset
REQ-015 rst=1 SHALL asynchronously force the following, aborting any burst and discarding buffered and in-flight data:
- state = IDLE;
- FIFO empty;
- in-flight count = 0;
- busy, done, out_valid, out_last, bram_we = 0;
- bram_addr = 0;
- out_data = 0.
- After rst deasserts, the first rising edge SHALL accept start.

Configuration
REQ-016 Macro BRAM_READER_STRIDE_EN SHALL control the stride feature.
- Defined: an extra input stride (ADDR_WIDTH bits) is sampled with start, and S = stride (stride 0 rereads base_addr length times).
- Undefined: the port is absent and S = 1.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Preload mem[i]=i+0x100. start, base=4, length=8, out_ready=1 -> 0x104..0x10B on consecutive cycles; first out_valid 3 cycles after start; out_last on 0x10B; done 1 cycle after that word is accepted.
- length=0 -> no out_valid; done one cycle after start; busy high for exactly that one cycle.
- base=1022, length=4, ADDR_WIDTH=10 -> addresses 1022, 1023, 0, 1 in order; data matches.
- length=6, out_ready toggling 1,0,0,1,0,1... -> all 6 words, in order, no duplicates; outputs stable while stalled.
- rst pulsed mid-burst after 3 words -> out_valid drops immediately; a new start, base=0, length=2 -> exactly mem[0], mem[1].
- With BRAM_READER_STRIDE_EN, base=0, stride=3, length=4 -> mem[0], mem[3], mem[6], mem[9]; a start asserted during that burst is ignored.
